// File: rtl/gcd_requester_if.sv
// ----------------------------------------------------------------------------
// gcd_requester_if: request/response streams and GCD core start/done bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface gcd_requester_if #(
  parameter int WIDTH = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_a;
  logic [WIDTH-1:0] rsp_b;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_timeout;

  logic             core_start;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  // Requester view: accepts requests, emits responses, drives the core.
  modport master (
    input  req_valid, req_a, req_b, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_timeout,
           core_start, core_a, core_b
  );

  // Environment view: upstream producer, downstream consumer and the core.
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_timeout,
           core_start, core_a, core_b
  );
endinterface

`default_nettype wire

// File: rtl/gcd_requester.sv
// ----------------------------------------------------------------------------
// gcd_requester: buffers operand pairs, sequences a GCD core, returns results
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gcd_requester #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic        clk,
  input  wire logic        reset,
  gcd_requester_if.master  bus,
  output logic             busy,
  output logic [7:0]       timeout_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     count_q;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         to_count_q;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_to_inc;
  logic [WIDTH-1:0]   w_head_a;
  logic [WIDTH-1:0]   w_head_b;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  assign w_full   = (count_q == FIFO_FULL);
  assign w_empty  = (count_q == '0);
  assign w_push   = bus.req_valid && !w_full;
  assign w_head_a = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
  assign w_head_b = mem_q[rd_ptr_q][WIDTH-1:0];

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {bus.req_a, bus.req_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      gcd_q      <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      to_count_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gcd_q     <= gcd_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      if (w_to_inc && (to_count_q != 8'hFF)) begin
        to_count_q <= to_count_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    w_pop     = 1'b0;
    w_to_inc  = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    gcd_d     = gcd_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          a_d       = w_head_a;
          b_d       = w_head_b;
          timeout_d = 1'b0;
          // A zero operand makes the answer the other operand; skip the core.
          if ((w_head_a == '0) || (w_head_b == '0)) begin
            gcd_d   = w_head_a | w_head_b;
            state_d = S_RESP;
          end else begin
            gcd_d   = '0;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_LOW;
      end

      S_WAIT_LOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TO_LAST) begin
          gcd_d     = '0;
          timeout_d = 1'b1;
          w_to_inc  = 1'b1;
          state_d   = S_RESP;
        end else if (!bus.core_done) begin
          state_d = S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the final allowed cycle still counts.
        if (bus.core_done) begin
          gcd_d   = bus.core_result;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          gcd_d     = '0;
          timeout_d = 1'b1;
          w_to_inc  = 1'b1;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready   = !w_full;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_a       = a_q;
  assign bus.rsp_b       = b_q;
  assign bus.rsp_gcd     = gcd_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.core_start  = (state_q == S_START);
  assign bus.core_a      = a_q;
  assign bus.core_b      = b_q;

  assign busy          = (state_q != S_IDLE) || !w_empty;
  assign timeout_count = to_count_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_requester.sv
// ----------------------------------------------------------------------------
// tb_gcd_requester: directed self-checking bench with a behavioural GCD core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gcd_requester;

  localparam int WIDTH = 8;
  localparam int TO    = 16;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [7:0] tcount;

  int total = 0;
  int bad   = 0;

  gcd_requester_if #(.WIDTH(WIDTH)) bus ();

  gcd_requester #(
    .WIDTH         (WIDTH),
    .DEPTH         (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .timeout_count(tcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    x = a;
    y = b;
    if (x == 0) return y;
    if (y == 0) return x;
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return x;
  endfunction

  // Behavioural core: 0 = normal, 1 = done stuck low, 2 = done stuck high.
  int         core_mode = 0;
  int         lat_cfg   = 3;
  int         core_cnt  = 0;
  logic       core_busy = 1'b0;
  logic [7:0] ca = '0;
  logic [7:0] cb = '0;
  int         start_cnt = 0;

  initial begin
    bus.core_done   = 1'b1;
    bus.core_result = '0;
  end

  always @(posedge clk) begin
    if (bus.core_start === 1'b1) start_cnt <= start_cnt + 1;
    if (bus.core_start === 1'b1 && core_mode != 2) begin
      bus.core_done <= 1'b0;
      ca            <= bus.core_a;
      cb            <= bus.core_b;
      core_cnt      <= lat_cfg;
      core_busy     <= 1'b1;
    end else if (core_busy && core_mode == 0) begin
      if (core_cnt <= 1) begin
        bus.core_done   <= 1'b1;
        bus.core_result <= ref_gcd(ca, cb);
        core_busy       <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_wait", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] g, input logic to, input int stall);
    int n;
    repeat (stall) @(negedge clk);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_a"},     32'(bus.rsp_a), 32'(a));
    chk({tag, "_b"},     32'(bus.rsp_b), 32'(b));
    chk({tag, "_gcd"},   32'(bus.rsp_gcd), 32'(g));
    chk({tag, "_to"},    32'(bus.rsp_timeout), 32'(to));
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!bus.core_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_start_wait"}, 32'(bus.core_start), 1);
  endtask

  // Cycles from the START cycle to the first cycle with rsp_valid high.
  task automatic measure_to(input string tag, input int exp);
    int n;
    wait_start(tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 100);
    chk({tag, "_latency"}, 32'(n), 32'(exp));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    logic [7:0] pa [5];
    logic [7:0] pb [5];

    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready",  32'(bus.req_ready), 1);
    chk("rst_rsp_valid",  32'(bus.rsp_valid), 0);
    chk("rst_core_start", 32'(bus.core_start), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_tcount",     32'(tcount), 0);
    chk("rst_core_a",     32'(bus.core_a), 0);
    chk("rst_rsp_gcd",    32'(bus.rsp_gcd), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single transaction through the core
    lat_cfg = 7;
    s = start_cnt;
    push(8'd12, 8'd18);
    wait_start("t1");
    chk("t1_start_high", 32'(bus.core_start), 1);
    @(negedge clk);
    chk("t1_start_pulse", 32'(bus.core_start), 0);
    n = 0;
    while (!bus.core_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t1_done", 32'(bus.core_done), 1);
    chk("t1_core_a", 32'(bus.core_a), 12);
    chk("t1_core_b", 32'(bus.core_b), 18);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    chk("t1_rsp_next", 32'(bus.rsp_valid), 1);
    get_rsp("t1", 8'd12, 8'd18, 8'd6, 1'b0, 0);
    chk("t1_starts", 32'(start_cnt - s), 1);

    // Zero-operand bypass
    s = start_cnt;
    push(8'd0, 8'd9);
    get_rsp("byp1", 8'd0, 8'd9, 8'd9, 1'b0, 0);
    push(8'd0, 8'd0);
    get_rsp("byp2", 8'd0, 8'd0, 8'd0, 1'b0, 0);
    chk("byp_no_start", 32'(start_cnt - s), 0);

    // Backpressure: 1 holding + 4 queued, 6th refused
    pa = '{8'd12, 8'd9, 8'd35, 8'd7, 8'd100};
    pb = '{8'd8,  8'd6, 8'd14, 8'd5, 8'd75};
    lat_cfg = 3;
    for (int i = 0; i < 5; i++) push(pa[i], pb[i]);
    chk("bp_full", 32'(bus.req_ready), 0);
    chk("bp_busy", 32'(busy), 1);
    bus.req_valid = 1'b1;
    bus.req_a     = 8'd21;
    bus.req_b     = 8'd14;
    repeat (4) @(negedge clk);
    chk("bp_still_full", 32'(bus.req_ready), 0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) get_rsp("bp", pa[i], pb[i], ref_gcd(pa[i], pb[i]), 1'b0, 0);
    repeat (20) @(negedge clk);
    chk("bp_no_sixth", 32'(bus.rsp_valid), 0);
    chk("bp_idle", 32'(busy), 0);

    // Timeout with done stuck low, then recovery
    core_mode = 1;
    push(8'd20, 8'd30);
    measure_to("to_low", TO + 1);
    get_rsp("to_low", 8'd20, 8'd30, 8'd0, 1'b1, 0);
    chk("to_low_count", 32'(tcount), 1);
    core_mode = 0;
    lat_cfg   = 4;
    push(8'd8, 8'd12);
    get_rsp("rec1", 8'd8, 8'd12, 8'd4, 1'b0, 0);

    // Timeout with done stuck high, then recovery
    core_mode = 2;
    push(8'd9, 8'd3);
    measure_to("to_high", TO + 1);
    get_rsp("to_high", 8'd9, 8'd3, 8'd0, 1'b1, 0);
    chk("to_high_count", 32'(tcount), 2);
    core_mode = 0;
    push(8'd8, 8'd12);
    get_rsp("rec2", 8'd8, 8'd12, 8'd4, 1'b0, 0);

    // Reset during WAIT_HIGH with entries queued
    lat_cfg = 10;
    push(8'd12, 8'd18);
    push(8'd3, 8'd6);
    push(8'd4, 8'd8);
    push(8'd5, 8'd10);
    repeat (2) @(negedge clk);
    chk("mr_busy_before", 32'(busy), 1);
    chk("mr_done_low", 32'(bus.core_done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid",  32'(bus.rsp_valid), 0);
    chk("mr_core_start", 32'(bus.core_start), 0);
    chk("mr_busy",       32'(busy), 0);
    chk("mr_req_ready",  32'(bus.req_ready), 1);
    chk("mr_tcount",     32'(tcount), 0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("mr_quiet", 32'(bus.rsp_valid), 0);
    lat_cfg = 3;
    push(8'd15, 8'd10);
    get_rsp("mr_after", 8'd15, 8'd10, 8'd5, 1'b0, 0);

    // Sweep 1..15 x 1..15 with random latency and backpressure
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        lat_cfg = int'($urandom_range(1, 6));
        push(8'(a), 8'(b));
        get_rsp("sweep", 8'(a), 8'(b), ref_gcd(8'(a), 8'(b)), 1'b0, int'($urandom_range(0, 3)));
      end
    end
    chk("sweep_tcount", 32'(tcount), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
